// File: rtl/multu_seq.sv
// Iterative shift-add multiplier, WIDTH cycles per product, signed or unsigned per request.
// Define MULTU_SEQ_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are all zero.
module multu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               sign_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] z
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CALC = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] z_q, z_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] sum;
  logic               finish;

  // Magnitude of the most negative value wraps to itself, which is the correct unsigned magnitude.
  assign a_mag = (sign_mode && a[WIDTH-1]) ? -a : a;
  assign b_mag = (sign_mode && b[WIDTH-1]) ? -b : b;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    z_d      = z_q;
    done_d   = 1'b0;
    sum      = '0;
    finish   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          neg_d    = sign_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = CNT_W'(WIDTH);
          state_d  = CALC;
        end
      end
      default: begin
        sum      = acc_q + (mplier_q[0] ? mcand_q : '0);
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
`ifdef MULTU_SEQ_EARLY_EXIT_EN
        finish   = (cnt_d == '0) || (mplier_d == '0);
`else
        finish   = (cnt_d == '0);
`endif
        if (finish) begin
          z_d     = neg_q ? -sum : sum;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      z_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      z_q      <= z_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q == CALC);
  assign done = done_q;
  assign z    = z_q;

endmodule

// File: doc/multu_seq.md
Name: multu_seq

Overview:
- Parametrised iterative shift-add multiplier. Successor to the fixed 32-bit MULTU.
- Adds a start/busy/done handshake, a WIDTH parameter, and run-time signed (MULT) or unsigned (MULTU) mode.
- Sits beside the ALU in the MIPS CPU datapath. It feeds the HI/LO registers with z[2*WIDTH-1:WIDTH] and z[WIDTH-1:0].
- The CPU stalls on busy.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH bits; legal range 4..64.
CNT_W, $clog2(WIDTH+1), iteration counter width; derived, do not override.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset.
start  input  1  request; sampled only in IDLE.
sign_mode  input  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled with start.
a  input  WIDTH  multiplicand; sampled with start.
b  input  WIDTH  multiplier; sampled with start.
busy  output  1  high while an operation is in progress.
done  output  1  single-cycle pulse when z is updated.
z  output  2*WIDTH  product; held until the next completion.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; busy=0; done=0; z=0; counter=0; internal operand/accumulator registers=0.
  - Reset asserted mid-operation aborts it immediately; no done pulse is produced.
- States: IDLE, CALC.
- IDLE:
  - start=1 at an edge (edge 0) latches the operands. In signed mode these are |a| and |b|, each as a WIDTH-bit unsigned magnitude, plus neg = a[MSB]^b[MSB]; in unsigned mode neg=0.
  - Same edge: accumulator cleared, counter=WIDTH, busy=1, state=CALC.
- CALC, one iteration per edge:
  - If multiplier LSB=1, add the shifted multiplicand into the 2*WIDTH accumulator.
  - Shift the multiplicand left by 1 and the multiplier right by 1; counter decrements.
- Completion edge (counter reaches 0, i.e. edge WIDTH):
  - z = neg ? two's-complement negation of the final accumulator : final accumulator.
  - done=1 for exactly the following cycle; busy=0; state=IDLE.
- Latency: WIDTH edges from the start edge to z valid. busy is high for WIDTH cycles.
- done and busy are never high together.
- start while busy=1 is ignored, with no queueing; operands presented then are discarded.
- Back-to-back: start may be high in the cycle done is high. The new operation begins on that edge, and z still holds the previous result until its own completion.
- Mode and operands changing during CALC have no effect.
- Width rules:
  - Signed magnitude of -2^(WIDTH-1) is 2^(WIDTH-1); it fits WIDTH unsigned bits, so no overflow.
  - Products are exact in 2*WIDTH bits in both modes.
- Operand zero: z=0 in both modes, including signed negative × 0 (neg path must yield 0, not -0 artefacts).

Optional Feature:
Macro: MULTU_SEQ_EARLY_EXIT_EN
- Defined:
  - CALC also completes on any edge where the remaining (post-shift) multiplier is zero. z, done and state behave exactly as on a normal completion.
  - Latency = max(1, p+1) edges, where p is the bit index of the highest set bit of the multiplier magnitude. b=0 completes on edge 1.
  - Results are identical to the non-early build.
- Undefined: latency is always WIDTH edges regardless of operands.

Test Plan:
- Reset check: reset low for 10 ns with start=1 -> z=0, busy=0, done=0 throughout. After release with start=0, the block stays IDLE.
- Unsigned, WIDTH=32, a=3, b=5, sign_mode=0 -> after 32 cycles done pulses once and z=0x0000000F_0000000F? No: z=0x00000000_0000000F. Also a=b=0xFFFFFFFF -> z=0xFFFFFFFE_00000001.
- Signed, sign_mode=1:
  - a=0xFFFFFFFD (-3), b=5 -> z=0xFFFFFFFF_FFFFFFF1.
  - a=b=0xFFFFFFFF -> z=1.
  - a=b=0x80000000 -> z=0x40000000_00000000.
  - a=0x80000000, b=0 -> z=0.
- Handshake:
  - Pulse start again on cycle 10 of a busy operation with different operands -> ignored; z equals the first product; exactly one done.
  - Start asserted during the done cycle -> second result follows 32 cycles later.
- Mid-operation reset: assert reset at cycle 15 of CALC -> z=0, busy=0 immediately; no done pulse; the next start runs a correct full operation.
- With MULTU_SEQ_EARLY_EXIT_EN defined:
  - a=7, b=1 -> done after 1 cycle, z=7.
  - b=0x00000100 -> done after 9 cycles.
  - b=0xFFFFFFFF unsigned -> done after 32 cycles.
